// File: rtl/dispatch_queue_if.sv
// Fetch-side push, downstream stall/flush and output-slot signals of dispatch_queue.
// master drives the fetch/control inputs; slave is the queue itself.
interface dispatch_queue_if #(
    parameter int DEPTH      = 8,
    parameter int INSN_WIDTH = 32,
    parameter int PC_WIDTH   = 64
);
    localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

    logic                  in_fetch_done;
    logic [INSN_WIDTH-1:0] in_fetch_insnbits;
    logic [PC_WIDTH-1:0]   in_fetch_pc;
    logic                  in_stall;
    logic                  in_flush;
    logic                  out_fetch_stall;
    logic                  out_reg_done;
    logic [INSN_WIDTH-1:0] out_reg_insnbits;
    logic [PC_WIDTH-1:0]   out_reg_pc;
    logic [CNT_WIDTH-1:0]  out_count;
    logic                  out_overflow;

    modport master (
        output in_fetch_done, in_fetch_insnbits, in_fetch_pc, in_stall, in_flush,
        input  out_fetch_stall, out_reg_done, out_reg_insnbits, out_reg_pc,
               out_count, out_overflow
    );

    modport slave (
        input  in_fetch_done, in_fetch_insnbits, in_fetch_pc, in_stall, in_flush,
        output out_fetch_stall, out_reg_done, out_reg_insnbits, out_reg_pc,
               out_count, out_overflow
    );
endinterface

// File: rtl/dispatch_queue.sv
// Circular instruction FIFO feeding a registered dispatch slot, with skid back-pressure and flush.
// Optional DISPATCH_QUEUE_BYPASS_EN: an empty queue loads a push straight into a free slot.
module dispatch_queue #(
    parameter int DEPTH      = 8,
    parameter int INSN_WIDTH = 32,
    parameter int PC_WIDTH   = 64,
    parameter int SKID       = 1
) (
    input logic             in_clk,
    input logic             in_rst_n,
    dispatch_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(DEPTH - SKID);

    logic [INSN_WIDTH-1:0] insn_mem [DEPTH];
    logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];

    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic                  slot_done;
    logic [INSN_WIDTH-1:0] slot_insn;
    logic [PC_WIDTH-1:0]   slot_pc;
    logic                  fetch_stall;
    logic                  overflow;

    logic                  slot_free;
    logic                  pop;
    logic                  bypass;
    logic                  push;
    logic                  drop;
    logic [CNT_W-1:0]      count_next;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        slot_free  = !slot_done || !bus.in_stall;
        pop        = slot_free && (count != '0);
        bypass     = 1'b0;
`ifdef DISPATCH_QUEUE_BYPASS_EN
        bypass     = slot_free && (count == '0) && bus.in_fetch_done && !bus.in_flush;
`endif
        // A full queue still accepts a push when the head leaves on the same edge.
        push       = bus.in_fetch_done && !bypass && ((count != FULL) || pop);
        drop       = bus.in_fetch_done && (count == FULL) && !pop;
        count_next = count + CNT_W'(push) - CNT_W'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            slot_done   <= 1'b0;
            slot_insn   <= '0;
            slot_pc     <= '0;
            fetch_stall <= 1'b0;
            overflow    <= 1'b0;
        end else if (bus.in_flush) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            slot_done   <= 1'b0;
            fetch_stall <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (pop) begin
                slot_insn <= insn_mem[head];
                slot_pc   <= pc_mem[head];
                slot_done <= 1'b1;
                head      <= head + 1'b1;
            end else if (bypass) begin
                slot_insn <= bus.in_fetch_insnbits;
                slot_pc   <= bus.in_fetch_pc;
                slot_done <= 1'b1;
            end else if (slot_free) begin
                slot_done <= 1'b0;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            count       <= count_next;
            overflow    <= overflow | drop;
            fetch_stall <= (count_next >= STALL_AT);
        end
    end

    // NOTE: storage has no reset; entries are only read after being written, which keeps it a plain RAM.
    always_ff @(posedge in_clk) begin
        if (push && !bus.in_flush) begin
            insn_mem[tail] <= bus.in_fetch_insnbits;
            pc_mem[tail]   <= bus.in_fetch_pc;
        end
    end

    assign bus.out_fetch_stall  = fetch_stall;
    assign bus.out_reg_done     = slot_done;
    assign bus.out_reg_insnbits = slot_insn;
    assign bus.out_reg_pc       = slot_pc;
    assign bus.out_count        = count;
    assign bus.out_overflow     = overflow;
endmodule

// File: tb/tb_dispatch_queue.sv
// Directed and randomized bench for dispatch_queue against a queue-based reference model.
// Honours DISPATCH_QUEUE_BYPASS_EN when the same macro is defined for the build.
module tb_dispatch_queue;
    localparam int DEPTH      = 8;
    localparam int INSN_WIDTH = 32;
    localparam int PC_WIDTH   = 64;
    localparam int SKID       = 1;

    typedef struct packed {
        logic [INSN_WIDTH-1:0] insn;
        logic [PC_WIDTH-1:0]   pc;
    } entry_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dispatch_queue_if #(.DEPTH(DEPTH), .INSN_WIDTH(INSN_WIDTH), .PC_WIDTH(PC_WIDTH)) bus ();

    dispatch_queue #(
        .DEPTH(DEPTH), .INSN_WIDTH(INSN_WIDTH), .PC_WIDTH(PC_WIDTH), .SKID(SKID)
    ) dut (
        .in_clk  (clk),
        .in_rst_n(rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    entry_t mq[$];
    logic   m_done;
    entry_t m_slot;
    logic   m_stall;
    logic   m_ovf;
    logic [PC_WIDTH-1:0] presented[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_done  = 1'b0;
        m_slot  = '0;
        m_stall = 1'b0;
        m_ovf   = 1'b0;
    endfunction

    // One clock edge of the queue, described as list operations on the pre-edge state.
    function automatic void model_edge(input bit push, input entry_t e, input bit stall, input bit flush);
        bit free;
        bit taken;
        if (flush) begin
            mq.delete();
            m_done  = 1'b0;
            m_stall = 1'b0;
            m_ovf   = 1'b0;
            return;
        end
        free  = !m_done || !stall;
        taken = 1'b0;
        if (free) begin
            if (mq.size() > 0) begin
                m_slot = mq.pop_front();
                m_done = 1'b1;
            end
`ifdef DISPATCH_QUEUE_BYPASS_EN
            else if (push) begin
                m_slot = e;
                m_done = 1'b1;
                taken  = 1'b1;
            end
`endif
            else m_done = 1'b0;
        end
        if (push && !taken) begin
            if (mq.size() < DEPTH) mq.push_back(e);
            else m_ovf = 1'b1;
        end
        m_stall = (mq.size() >= DEPTH - SKID);
    endfunction

    task automatic compare_all();
        check("count", 64'(bus.out_count), 64'(mq.size()));
        check("reg_done", 64'(bus.out_reg_done), 64'(m_done));
        check("fetch_stall", 64'(bus.out_fetch_stall), 64'(m_stall));
        check("overflow", 64'(bus.out_overflow), 64'(m_ovf));
        if (m_done) begin
            check("reg_insn", 64'(bus.out_reg_insnbits), 64'(m_slot.insn));
            check("reg_pc", bus.out_reg_pc, m_slot.pc);
        end
    endtask

    task automatic cycle(input bit push, input logic [INSN_WIDTH-1:0] insn,
                         input logic [PC_WIDTH-1:0] pc, input bit stall, input bit flush);
        entry_t e;
        e.insn = insn;
        e.pc   = pc;
        bus.in_fetch_done     = push;
        bus.in_fetch_insnbits = insn;
        bus.in_fetch_pc       = pc;
        bus.in_stall          = stall;
        bus.in_flush          = flush;
        if (bus.out_reg_done && !stall && !flush) presented.push_back(bus.out_reg_pc);
        @(posedge clk);
        model_edge(push, e, stall, flush);
        #1;
        compare_all();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_done"}, 64'(bus.out_reg_done), 64'd0);
        check({tag, "_count"}, 64'(bus.out_count), 64'd0);
        check({tag, "_stall"}, 64'(bus.out_fetch_stall), 64'd0);
        check({tag, "_ovf"}, 64'(bus.out_overflow), 64'd0);
        check({tag, "_insn"}, 64'(bus.out_reg_insnbits), 64'd0);
        check({tag, "_pc"}, bus.out_reg_pc, 64'd0);
    endtask

    initial begin
        bus.in_fetch_done     = 1'b0;
        bus.in_fetch_insnbits = '0;
        bus.in_fetch_pc       = '0;
        bus.in_stall          = 1'b0;
        bus.in_flush          = 1'b0;
        model_reset();

        // Reset state
        #12;
        check_cleared("reset");
        #1 rst_n = 1'b1;

        // Single push and its latency
        cycle(1'b1, 32'hD280_0020, 64'h1000, 1'b0, 1'b0);
`ifdef DISPATCH_QUEUE_BYPASS_EN
        check("lat_e1_done", 64'(bus.out_reg_done), 64'd1);
        check("lat_e1_pc", bus.out_reg_pc, 64'h1000);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        check("lat_e2_done", 64'(bus.out_reg_done), 64'd0);
`else
        check("lat_e1_done", 64'(bus.out_reg_done), 64'd0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        check("lat_e2_done", 64'(bus.out_reg_done), 64'd1);
        check("lat_e2_insn", 64'(bus.out_reg_insnbits), 64'hD280_0020);
        check("lat_e2_pc", bus.out_reg_pc, 64'h1000);
        check("lat_e2_count", 64'(bus.out_count), 64'd0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        check("lat_e3_done", 64'(bus.out_reg_done), 64'd0);
`endif

        // Fill under stall, then overflow
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 32'h1300_0000 + 32'(i), 64'h1000 + 64'(4 * i), 1'b1, 1'b0);
        check("fill_count7", 64'(bus.out_count), 64'd7);
        check("fill_stall", 64'(bus.out_fetch_stall), 64'd1);
        check("fill_no_ovf", 64'(bus.out_overflow), 64'd0);
        cycle(1'b1, 32'h1300_0008, 64'h1020, 1'b1, 1'b0);
        check("fill_count8", 64'(bus.out_count), 64'd8);
        check("fill_no_ovf8", 64'(bus.out_overflow), 64'd0);
        cycle(1'b1, 32'h1300_0009, 64'h1024, 1'b1, 1'b0);
        check("full_drop_ovf", 64'(bus.out_overflow), 64'd1);
        check("full_drop_count", 64'(bus.out_count), 64'd8);

        // Flush with a same-edge push while stalled
        cycle(1'b0, '0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 32'h1400_0000 + 32'(i), 64'h1100 + 64'(4 * i), 1'b1, 1'b0);
        check("pre_flush_count", 64'(bus.out_count), 64'd5);
        cycle(1'b1, 32'h0BAD_0BAD, 64'hDEAD00, 1'b1, 1'b1);
        check("flush_count", 64'(bus.out_count), 64'd0);
        check("flush_done", 64'(bus.out_reg_done), 64'd0);
        check("flush_stall", 64'(bus.out_fetch_stall), 64'd0);
        presented.delete();
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
        check("flush_nothing_out", 64'(presented.size()), 64'd0);

        // Continuous streaming: 20 in, in order, count stays low
        presented.delete();
        for (int i = 0; i < 24; i++) begin
            if (i < 20) cycle(1'b1, 32'h2200_0000 + 32'(i), 64'h2000 + 64'(4 * i), 1'b0, 1'b0);
            else        cycle(1'b0, '0, '0, 1'b0, 1'b0);
            check("stream_count_le1", 64'(bus.out_count <= 1), 64'd1);
        end
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        check("stream_total", 64'(presented.size()), 64'd20);
        for (int i = 0; i < presented.size(); i++)
            check($sformatf("stream_pc%0d", i), presented[i], 64'h2000 + 64'(4 * i));

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h5500_0000 + 32'(i), 64'h5000 + 64'(4 * i), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_cleared("async_rst");
        model_reset();
        #2 rst_n = 1'b1;
        presented.delete();
        cycle(1'b1, 32'h3300_0000, 64'h3000, 1'b0, 1'b0);
        for (int i = 0; i < 6 && presented.size() == 0; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
        check("post_rst_presented", 64'(presented.size() > 0), 64'd1);
        if (presented.size() > 0) check("post_rst_first_pc", presented[0], 64'h3000);

        // Toggling stall: each instruction presented once, in order
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
        presented.delete();
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 32'h4400_0000 + 32'(i), 64'h4000 + 64'(4 * i), bit'(i % 2), 1'b0);
        for (int i = 0; i < 14; i++) cycle(1'b0, '0, '0, bit'(i % 2), 1'b0);
        check("toggle_total", 64'(presented.size()), 64'd6);
        for (int i = 0; i < presented.size(); i++)
            check($sformatf("toggle_pc%0d", i), presented[i], 64'h4000 + 64'(4 * i));

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++)
            cycle(bit'($urandom_range(0, 99) < 65), $urandom, {$urandom, $urandom},
                  bit'($urandom_range(0, 99) < 45), bit'($urandom_range(0, 99) < 3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- Parametrised instruction buffer between fetch and the decode/dispatch stage; successor to the single-register insnbits latch in front of the decoder.
- Holds up to DEPTH fetched instruction words with their PCs in a circular FIFO and presents them one at a time through a registered output slot.
- Decouples fetch from downstream stalls, applies registered back-pressure to fetch with a skid margin, and supports a synchronous flush on branch redirect.

Parameters:
- DEPTH, 8, FIFO entries, excluding the output slot; power of two, minimum 2.
- INSN_WIDTH, 32, instruction word width.
- PC_WIDTH, 64, PC width carried alongside each instruction.
- SKID, 1, free entries reserved when out_fetch_stall asserts; range 0 to DEPTH-1.

Ports:
- in_clk, in, 1, clock; all state updates on the rising edge.
- in_rst_n, in, 1, asynchronous active-low reset.
- in_fetch_done, in, 1, push request: fetch presents a valid instruction this cycle.
- in_fetch_insnbits, in, INSN_WIDTH, instruction word to push.
- in_fetch_pc, in, PC_WIDTH, PC of the pushed instruction.
- in_stall, in, 1, downstream cannot accept; the output slot holds its contents.
- in_flush, in, 1, synchronous flush of the FIFO and output slot.
- out_fetch_stall, out, 1, registered back-pressure to fetch.
- out_reg_done, out, 1, output slot holds a valid instruction.
- out_reg_insnbits, out, INSN_WIDTH, instruction in the output slot.
- out_reg_pc, out, PC_WIDTH, PC in the output slot.
- out_count, out, $clog2(DEPTH)+1, FIFO occupancy, excluding the output slot.
- out_overflow, out, 1, sticky: a push was dropped because the FIFO was full.

Behaviour:
- Reset (in_rst_n low, asynchronous): head, tail and count go to 0. out_reg_done, out_fetch_stall and out_overflow go to 0. out_reg_insnbits and out_reg_pc go to 0. FIFO storage is not reset.
- Transfer rule: an instruction leaves the output slot on a cycle with out_reg_done=1 and in_stall=0.
- Slot free: the output slot is free at an edge if out_reg_done=0 or a transfer occurs that cycle.
- Refill: at each edge where the slot is free:
  - if count>0: load head entry into the slot, set out_reg_done=1, advance head, decrement count;
  - else: clear out_reg_done.
- Hold: if the slot is not free, the slot and out_reg_done hold.
- Push: in_fetch_done=1 and count<DEPTH writes the entry at tail, advances tail and increments count.
- Simultaneous push and pop: count is unchanged; head and tail both advance.
- Empty-queue timing: push at edge N is stored at N, loaded into the slot at N+1, so out_reg_done=1 after N+1. Latency is 2 edges.
- Full push: push while count==DEPTH (and no pop that edge) is dropped and sets out_overflow. out_overflow clears only on reset or flush.
- Push while count==DEPTH with a same-edge pop is accepted.
- Pointers: head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH. count ranges 0..DEPTH.
- out_fetch_stall: registered; equals (next count >= DEPTH-SKID), computed from the post-edge count. With SKID=1 a fetch that reacts one cycle late cannot overflow the FIFO.
- Flush: in_flush=1 at an edge has highest priority.
  - head, tail and count go to 0; out_reg_done, out_fetch_stall and out_overflow go to 0.
  - A push in the same cycle is discarded.
  - The output slot is invalidated even if in_stall=1.
- in_stall does not block pushes; the FIFO keeps filling while the slot holds.

Optional Feature:
- Macro: DISPATCH_QUEUE_BYPASS_EN.
- Defined: when count==0, the slot is free and a push occurs (no flush), the pushed instruction loads directly into the output slot at the same edge. out_reg_done=1 after edge N (1-edge latency). count is unchanged and the FIFO is not written.
- Undefined: all pushes pass through FIFO storage; empty-queue latency is 2 edges.

Test Plan:
- Reset, then single push (insnbits=0xD2800020, pc=0x1000), in_stall=0: out_reg_done=1 with those values after 2 edges (1 with bypass), out_count=0 after; out_reg_done=0 the next edge.
- Hold in_stall=1, push 8 instructions pc=0x1000..0x101C (DEPTH=8, SKID=1) into an empty queue; the first occupies the output slot (with bypass it skips the FIFO and all later pushes use the FIFO). out_fetch_stall=1 once post-edge count>=7. The pushes fit without overflow; a further push when count==8 is dropped and out_overflow=1.
- Continuous push and pop, 20 instructions, in_stall=0: outputs appear in PC order 0x2000..0x204C with no gaps after the first; pointers wrap twice; out_count never exceeds 1.
- With in_stall=1 and 5 queued, assert in_flush together with a push: next edge out_count=0, out_reg_done=0, out_fetch_stall=0, and the pushed instruction never appears.
- Assert in_rst_n=0 mid-burst between clock edges: all outputs clear immediately; after release, a new push of pc=0x3000 is the first instruction presented.
- With in_stall toggling every other cycle, 6 pushes: each instruction is presented exactly once, in order, and is held unchanged for every cycle in_stall=1.
